// File: rtl/fp_mul_pkg.sv
// Shared types for the FP multiplier arbiter.
// Rounding modes, tag bundle and FSM state encoding.
package fp_mul_pkg;

  localparam int FP_W    = 32;
  localparam int MAX_IDW = 3;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rmode_e;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
    logic               err;
  } fp_tag_t;

  function automatic logic rm_bad(input logic [2:0] rm);
    return rm > 3'd4;
  endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr.sv
// Combinational round-robin arbiter.
// Scans upward from ptr with wrap-around; one-hot or zero grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one FP32 multiplier among N_REQ requesters.
// Optional counters: define FP_MUL_ARB_STATS_EN.
module fp_mul_arbiter
  import fp_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 2,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef FP_MUL_ARB_STATS_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_issued,
  output logic [15:0]           stat_ovrf,
  output logic [15:0]           stat_udrf,
`endif
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*FP_W-1:0] req_x,
  input  logic [N_REQ*FP_W-1:0] req_y,
  input  logic [N_REQ*3-1:0]    req_rmode,
  input  logic                  flush,
  output logic                  drained,
  output logic                  busy,
  output logic [FP_W-1:0]       mul_x,
  output logic [FP_W-1:0]       mul_y,
  output logic [2:0]            mul_rmode,
  input  logic [FP_W-1:0]       mul_z,
  input  logic                  mul_ovrf,
  input  logic                  mul_udrf,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [FP_W-1:0]       rsp_z,
  output logic                  rsp_ovrf,
  output logic                  rsp_udrf,
  output logic                  rsp_rm_err
);

  arb_state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [FP_W-1:0] x_q, x_d;
  logic [FP_W-1:0] y_q, y_d;
  logic [2:0]      rm_q, rm_d;

  fp_tag_t iss_q, iss_d;
  fp_tag_t [MUL_LAT-1:0] tag_q, tag_d;
  fp_tag_t last;

  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [FP_W-1:0]  rsp_z_q, rsp_z_d;
  logic             rsp_ovrf_q, rsp_ovrf_d;
  logic             rsp_udrf_q, rsp_udrf_d;
  logic             rsp_err_q, rsp_err_d;

  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_id;
  logic             hs;
  logic             pipe_any;
  logic [FP_W-1:0]  sel_x;
  logic [FP_W-1:0]  sel_y;
  logic [2:0]       sel_rm;

  assign arb_req = (state_q == DRAIN || flush) ? '0 : req_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr (
    .req (arb_req),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) gnt_id = IDW'(i);
    end
  end

  always_comb begin
    sel_x  = req_x[gnt_id*FP_W +: FP_W];
    sel_y  = req_y[gnt_id*FP_W +: FP_W];
    sel_rm = req_rmode[gnt_id*3 +: 3];
  end

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    rm_d  = rm_q;
    iss_d = '0;
    ptr_d = ptr_q;
    if (hs) begin
      x_d             = sel_x;
      y_d             = sel_y;
      rm_d            = rm_bad(sel_rm) ? RNE : sel_rm;
      iss_d.valid     = 1'b1;
      iss_d.id[IDW-1:0] = gnt_id;
      iss_d.err       = rm_bad(sel_rm);
      ptr_d = (int'(gnt_id) == N_REQ-1) ? '0 : gnt_id + 1'b1;
    end
  end

  // iss_q rides with mul_x; the tag stages then cover the multiplier latency
  always_comb begin
    tag_d[0] = iss_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  assign last = tag_q[MUL_LAT-1];

  always_comb begin
    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_ovrf_d  = rsp_ovrf_q;
    rsp_udrf_d  = rsp_udrf_q;
    rsp_err_d   = rsp_err_q;
    if (last.valid) begin
      rsp_valid_d[last.id[IDW-1:0]] = 1'b1;
      rsp_id_d   = last.id[IDW-1:0];
      rsp_z_d    = mul_z;
      rsp_ovrf_d = mul_ovrf;
      rsp_udrf_d = mul_udrf;
      rsp_err_d  = last.err;
    end
  end

  always_comb begin
    pipe_any = iss_q.valid;
    for (int i = 0; i < MUL_LAT; i++) begin
      pipe_any = pipe_any | tag_q[i].valid;
    end
  end

  assign busy = pipe_any | (|rsp_valid_q);

  always_comb begin
    state_d = state_q;
    drained = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush)   state_d = DRAIN;
        else if (hs) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (flush)             state_d = DRAIN;
        else if (!busy && !hs) state_d = IDLE;
      end
      DRAIN: begin
        if (!busy) begin
          state_d = IDLE;
          drained = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rm_q        <= '0;
      iss_q       <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_ovrf_q  <= 1'b0;
      rsp_udrf_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rm_q        <= rm_d;
      iss_q       <= iss_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_ovrf_q  <= rsp_ovrf_d;
      rsp_udrf_q  <= rsp_udrf_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mul_x      = x_q;
  assign mul_y      = y_q;
  assign mul_rmode  = rm_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_ovrf   = rsp_ovrf_q;
  assign rsp_udrf   = rsp_udrf_q;
  assign rsp_rm_err = rsp_err_q;

`ifdef FP_MUL_ARB_STATS_EN
  logic [31:0] iss_cnt_q, iss_cnt_d;
  logic [15:0] ov_cnt_q, ov_cnt_d;
  logic [15:0] ud_cnt_q, ud_cnt_d;
  logic        rsp_any;

  assign rsp_any = |rsp_valid_q;

  always_comb begin
    iss_cnt_d = iss_cnt_q;
    ov_cnt_d  = ov_cnt_q;
    ud_cnt_d  = ud_cnt_q;
    if (stat_clr) begin
      iss_cnt_d = '0;
      ov_cnt_d  = '0;
      ud_cnt_d  = '0;
    end else begin
      if (hs && !(&iss_cnt_q))
        iss_cnt_d = iss_cnt_q + 1'b1;
      if (rsp_any && rsp_ovrf_q && !(&ov_cnt_q))
        ov_cnt_d = ov_cnt_q + 1'b1;
      if (rsp_any && rsp_udrf_q && !(&ud_cnt_q))
        ud_cnt_d = ud_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_cnt_q <= '0;
      ov_cnt_q  <= '0;
      ud_cnt_q  <= '0;
    end else begin
      iss_cnt_q <= iss_cnt_d;
      ov_cnt_q  <= ov_cnt_d;
      ud_cnt_q  <= ud_cnt_d;
    end
  end

  assign stat_issued = iss_cnt_q;
  assign stat_ovrf   = ov_cnt_q;
  assign stat_udrf   = ud_cnt_q;
`endif

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one 32-bit IEEE-754 single-precision multiplier (`top`: `fp_X`, `fp_Y`, `r_mode` in; `fp_Z`, `ovrf`, `udrf` out) among N_REQ requesters.
- Round-robin arbitration; at most one issue per cycle.
- Tags each operation with its requester ID through a latency-matched pipeline and routes the result back.
- Flush/drain control so software can quiesce the multiplier.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MUL_LAT, 2, multiplier latency in cycles from mul_x/mul_y/mul_rmode valid to mul_z valid (>=1).
- IDW, $clog2(N_REQ), requester ID width.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester operation valid
- req_ready  out  N_REQ  per-requester grant; handshake = valid & ready at clk edge
- req_x  in  N_REQ*32  operand X per requester (IEEE-754 single)
- req_y  in  N_REQ*32  operand Y per requester
- req_rmode  in  N_REQ*3  rounding mode per requester (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM)
- flush  in  1  stop granting and drain in-flight operations
- drained  out  1  one-cycle pulse when drain completes
- busy  out  1  high while any operation is in flight
- mul_x  out  32  to multiplier fp_X
- mul_y  out  32  to multiplier fp_Y
- mul_rmode  out  3  to multiplier r_mode
- mul_z  in  32  from multiplier fp_Z
- mul_ovrf  in  1  from multiplier ovrf
- mul_udrf  in  1  from multiplier udrf
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe
- rsp_id  out  IDW  requester ID of the current response
- rsp_z  out  32  product
- rsp_ovrf  out  1  overflow flag of the product
- rsp_udrf  out  1  underflow flag of the product
- rsp_rm_err  out  1  the request carried an illegal r_mode (5..7)

Behaviour:
- Reset values:
  - req_ready, rsp_valid: 0.
  - mul_x, mul_y, mul_rmode: 0.
  - rsp_id, rsp_z, rsp_ovrf, rsp_udrf, rsp_rm_err: 0.
  - busy, drained: 0.
  - Round-robin pointer: 0.
  - Tag pipeline: all invalid.
  - State: IDLE.
- FSM states:
  - IDLE: no operation in flight.
  - ACTIVE: operations in flight or being issued.
  - DRAIN: flush seen; in-flight operations completing.
- FSM transitions:
  - IDLE -> ACTIVE on any handshake.
  - ACTIVE -> IDLE when the pipeline is empty and there is no handshake.
  - IDLE/ACTIVE -> DRAIN when flush=1.
  - DRAIN -> IDLE when the pipeline is empty; drained pulses 1 in that cycle.
  - flush while in IDLE: DRAIN is entered for one cycle, then drained pulses.
- Arbitration:
  - req_ready is combinational.
  - It is one-hot (or zero): the first requester with req_valid=1 scanning from the RR pointer upward, with wrap-around.
  - req_ready is forced 0 in DRAIN and whenever flush=1.
  - After a handshake by requester k, the pointer moves to (k+1) mod N_REQ.
  - With no handshake, the pointer holds.
- Issue:
  - On the handshake edge, the granted operands and r_mode are registered onto mul_x, mul_y, mul_rmode.
  - r_mode > 4 is sent as 0 (RNE); an err bit is carried in the tag.
  - When no request is granted, mul_* hold their previous value.
- Tag pipeline:
  - MUL_LAT stages, each holding {valid, id, err}; shifts every cycle.
  - Stage 0 is loaded with the handshake result.
- Response timing:
  - When the last stage is valid, mul_z/mul_ovrf/mul_udrf are captured into the rsp_* registers.
  - rsp_valid[id] is 1 for exactly one cycle.
  - Latency from handshake edge to rsp_valid high is MUL_LAT+1 cycles.
  - Throughput is 1 operation per cycle.
- Responses have no backpressure; requesters must accept them.
- busy = any tag stage valid OR rsp_valid nonzero.
- Simultaneous flush and req_valid: no grant in that cycle.
- Reset mid-operation: all in-flight tags are discarded; no rsp_valid is produced for them.

Optional Feature:
- Macro: FP_MUL_ARB_STATS_EN.
- When defined, adds output ports:
  - stat_issued, 32 bits.
  - stat_ovrf, 16 bits.
  - stat_udrf, 16 bits.
  - stat_clr, 1-bit input.
- Counter rules:
  - stat_issued increments on each handshake.
  - stat_ovrf increments on each response with ovrf=1; stat_udrf on each response with udrf=1.
  - All counters saturate at all-ones.
  - All counters are cleared by rst or by stat_clr; stat_clr wins over a same-cycle increment.
- When not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fp_mul_pkg holds:
  - typedef rmode_e with RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4.
  - Constant FP_W=32.
  - typedef fp_tag_t {valid, id, err}.
  - typedef arb_state_e {IDLE, ACTIVE, DRAIN}.
- One sub-module, rr_arbiter: N_REQ request vector plus pointer in, one-hot grant out, purely combinational.

Test Plan:
- Single op, N_REQ=4, MUL_LAT=2:
  - Stimulus: req 1 sends x=0x3FC00000 (1.5), y=0x40000000 (2.0), rmode 0.
  - Required: 3 cycles after the handshake, rsp_valid=4'b0010, rsp_id=1, rsp_z=0x40400000, ovrf=udrf=0.
- All four requesters valid continuously:
  - Required: grants in order 0,1,2,3,0 on consecutive cycles.
  - Responses arrive in the same order, one per cycle, each rsp_id matching its grant.
- Overflow:
  - Stimulus: x=0x7F000000, y=0x7F000000 from req 2.
  - Required: rsp_ovrf=1, rsp_id=2, rsp_valid=4'b0100.
- Illegal rounding mode:
  - Stimulus: req 3 with rmode=6.
  - Required: mul_rmode=0 in the issue cycle; rsp_rm_err=1 on req 3's response.
- Flush with 2 ops in flight and req 0 still valid:
  - Required: no further grant; both responses delivered; drained pulses exactly once; state returns to IDLE; req 0 is granted afterwards.
- Reset mid-operation:
  - Stimulus: assert rst 1 cycle after a handshake.
  - Required: no rsp_valid for that op; busy=0 and all outputs at reset values on the following cycle.
